itcm_port_arbiter: RTL and testbench
====================================

# itcm_port_arbiter

Arbitrates the single-port instruction TCM between the instruction-fetch requester and the load/store requester of the `cpu` core. Each cycle it grants at most one access. It drives the ITCM port and routes the one-cycle-latency read data back to whichever requester owns it. Load/store has fixed priority, with a bounded-starvation counter that guarantees forward progress for fetch.

## Interface
Parameters:
- AW, 14, word-address width of the ITCM (4096 x 32-bit words default = 16 KiB at AW=12; 14 gives 64 KiB)
- MAX_STALL, 4, consecutive denied fetch cycles before fetch is forced to win; legal range 1..15

Ports (clock and reset first):
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  AW  fetch word address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid (registered)
- if_rdata  out  32  fetch read data
- ls_req  in  1  load/store request; held with payload stable until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_be  in  4  store byte enables
- ls_addr  in  AW  load/store word address
- ls_wdata  in  32  store data
- ls_gnt  out  1  load/store accepted this cycle (combinational)
- ls_rvalid  out  1  load/store completion (registered; pulses for loads and stores)
- ls_rdata  out  32  load read data
- mem_en  out  1  ITCM access enable
- mem_we  out  4  ITCM byte write enables (0 on reads)
- mem_addr  out  AW  ITCM word address
- mem_wdata  out  32  ITCM write data
- mem_rdata  in  32  ITCM read data, valid one cycle after mem_en

## Operation
- State: stall counter `stall_cnt` (4 bits), response owner register `rsp_own` (NONE/IF/LS).
- Arbitration, evaluated each cycle:
  - Only one request present: that requester is granted.
  - Both present and stall_cnt < MAX_STALL: LS is granted and stall_cnt increments.
  - Both present and stall_cnt == MAX_STALL: IF is granted and stall_cnt clears to 0.
  - Whenever IF is granted, or if_req is low, stall_cnt clears to 0.
- Memory port:
  - mem_en = if_gnt | ls_gnt.
  - mem_addr, mem_wdata and mem_we come from the granted requester.
  - mem_we = ls_be when LS is granted with ls_we=1; otherwise 4'b0.
  - When neither is granted, mem_we=0 and mem_addr/mem_wdata are don't-care.
- Response routing:
  - rsp_own latches the grant owner at the clock edge (NONE if no grant).
  - Next cycle: if_rvalid = (rsp_own==IF) and ls_rvalid = (rsp_own==LS).
  - if_rdata = ls_rdata = mem_rdata; only meaningful with the matching rvalid.
  - Store responses carry undefined rdata.
- Back-to-back: a new grant is allowed every cycle, including the cycle the previous rvalid is asserted. Responses return in grant order, one per cycle.
- Requesters are never back-pressured on responses; rvalid is a one-cycle pulse with no ready.

## Timing
- Reset values: if_rvalid=0, ls_rvalid=0, rsp_own=NONE, stall_cnt=0. Grants and mem_* outputs follow inputs combinationally (with no request during reset: mem_en=0, mem_we=0).
- Grant latency: 0 cycles, i.e. gnt in the same cycle as req when it wins.
- Read latency: rvalid exactly 1 cycle after gnt.
- Throughput: 1 access per cycle total.
- Worst-case fetch wait under continuous LS traffic: MAX_STALL denied cycles, then granted on cycle MAX_STALL+1.
- Reset mid-operation: an outstanding response is dropped (no rvalid after reset deasserts); stall_cnt restarts at 0.
- Simultaneous events:
  - LS request arriving in the cycle IF is forced: LS loses and stays held.
  - Deassertion of if_req while stalled clears stall_cnt with no grant.
- No path exists from mem_rdata to any grant (no combinational loop).

## Test plan
- Fetch only: if_req=1 at if_addr=0x010 for 3 cycles, mem_rdata returns 0x00000013 each -> if_gnt=1 every cycle; mem_addr=0x010; if_rvalid=1 one cycle later each cycle with if_rdata=0x00000013; ls_rvalid stays 0.
- Store then load: ls_req with ls_we=1, be=4'b0011, addr=0x020, wdata=0xDEADBEEF, then a load from 0x020 -> mem_we=4'b0011 on cycle 0 and 0 on cycle 1; ls_rvalid pulses on cycles 1 and 2.
- Contention: if_req and ls_req both held high continuously, MAX_STALL=4 -> grant pattern LS,LS,LS,LS,IF repeating; if_rvalid once every 5 cycles.
- Fetch drops while stalled: both requesting for 3 cycles, if_req low 1 cycle, then both requesting again -> stall_cnt resets; IF is granted only after 4 further LS grants.
- Reset mid-access: assert reset in the cycle after an LS grant -> ls_rvalid=0 and if_rvalid=0 throughout and after reset; first post-reset grant behaves as from the idle state.
- Interleaved ordering: alternate single IF and LS requests at addresses 0x100/0x200 with mem_rdata tied to mem_addr -> each rvalid carries data matching its own requester's address, with no swaps.

Source files
------------

// File: rtl/itcm_port_arbiter.sv
// itcm_port_arbiter: shares the single-port ITCM between instruction fetch (IF) and load/store (LS).
// Latency: grant is combinational in the request cycle; rvalid/rdata follow exactly one cycle after grant.
// Backpressure: a losing requester holds its request; LS has priority, IF is forced after MAX_STALL denials.
//
// Ports:
//   clk, reset                    core clock, asynchronous active-high reset
//   if_req/if_addr -> if_gnt      fetch request channel, granted combinationally
//   if_rvalid/if_rdata            fetch response, one cycle after if_gnt
//   ls_req/ls_we/ls_be/ls_addr/ls_wdata -> ls_gnt   load/store request channel
//   ls_rvalid/ls_rdata            load/store completion (pulses for stores too)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata      ITCM port, read data one cycle after mem_en
module itcm_port_arbiter #(
    parameter int AW        = 14,
    parameter int MAX_STALL = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [3:0]    ls_be,
    input  logic [AW-1:0] ls_addr,
    input  logic [31:0]   ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [31:0]   ls_rdata,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [3:0] LP_MAX_STALL = 4'(MAX_STALL);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } own_t;

    logic [3:0] r_stall_cnt;
    own_t       r_rsp_own;

    logic [3:0] w_stall_cnt_nxt;
    own_t       w_rsp_own_nxt;
    logic       w_force_if;
    logic       w_if_gnt;
    logic       w_ls_gnt;

    // Fetch wins when it is alone, or when it has already been denied MAX_STALL times.
    // Only the stall counter and the request lines feed the grants; mem_rdata never does.
    assign w_force_if = (r_stall_cnt == LP_MAX_STALL);
    assign w_if_gnt   = if_req & (~ls_req | w_force_if);
    assign w_ls_gnt   = ls_req & ~w_if_gnt;

    assign if_gnt = w_if_gnt;
    assign ls_gnt = w_ls_gnt;

    // Memory port follows the granted requester; fetch never writes.
    assign mem_en    = w_if_gnt | w_ls_gnt;
    assign mem_we    = (w_ls_gnt & ls_we) ? ls_be : 4'b0000;
    assign mem_addr  = w_ls_gnt ? ls_addr : if_addr;
    assign mem_wdata = w_ls_gnt ? ls_wdata : 32'h0;

    always_comb begin
        w_stall_cnt_nxt = r_stall_cnt;
        w_rsp_own_nxt   = OWN_NONE;

        // A denied cycle is one where fetch is still asking and LS took the port.
        if (!if_req || w_if_gnt) begin
            w_stall_cnt_nxt = 4'd0;
        end else if (w_ls_gnt) begin
            w_stall_cnt_nxt = r_stall_cnt + 4'd1;
        end

        if (w_if_gnt) begin
            w_rsp_own_nxt = OWN_IF;
        end else if (w_ls_gnt) begin
            w_rsp_own_nxt = OWN_LS;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= 4'd0;
            r_rsp_own   <= OWN_NONE;
        end else begin
            r_stall_cnt <= w_stall_cnt_nxt;
            r_rsp_own   <= w_rsp_own_nxt;
        end
    end

    // Responses: the single owner register keeps them in grant order, one per cycle.
    assign if_rvalid = (r_rsp_own == OWN_IF);
    assign ls_rvalid = (r_rsp_own == OWN_LS);
    assign if_rdata  = mem_rdata;
    assign ls_rdata  = mem_rdata;

endmodule

// File: tb/tb_itcm_port_arbiter.sv
module tb_itcm_port_arbiter;

    localparam int AW = 14;
    localparam int MS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          ls_req;
    logic          ls_we;
    logic [3:0]    ls_be;
    logic [AW-1:0] ls_addr;
    logic [31:0]   ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [31:0]   ls_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    itcm_port_arbiter #(.AW(AW), .MAX_STALL(MS)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_be     (ls_be),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural ITCM: one-cycle read latency, byte-enable writes, optional
    // "tie" mode that returns the address itself as data.
    logic        tie = 1'b0;
    logic [31:0] itcm    [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] mrd;
    assign mem_rdata = mrd;

    function automatic logic [31:0] init_val(input int i);
        if (i == 16) return 32'h0000_0013;
        return 32'(i) * 32'h0100_0193 + 32'h55;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) itcm[i] <= init_val(i);
            mrd <= 32'h0;
        end else if (mem_en) begin
            mrd <= tie ? 32'(mem_addr) : itcm[mem_addr[9:0]];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) itcm[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference model state, in spec terms: how many times fetch has been
    // denied in a row, and who owns the response due this cycle.
    int          denied    = 0;
    int          own       = 0;  // 0 none, 1 fetch, 2 load/store
    logic        own_store = 1'b0;
    logic [31:0] own_data  = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check outputs against the model,
    // then advance the model at the posedge.
    task automatic cyc(input logic r, input logic ir, input logic [AW-1:0] ia,
                       input logic lr, input logic lwe, input logic [3:0] lbe,
                       input logic [AW-1:0] la, input logic [31:0] lwd,
                       output logic gi, output logic gl, output logic obs_if);
        logic        egi, egl, nst;
        logic [3:0]  ewe;
        logic [AW-1:0] sel;
        logic [31:0] ndat;
        int          nd, nown;
        @(negedge clk);
        reset = r; if_req = ir; if_addr = ia;
        ls_req = lr; ls_we = lwe; ls_be = lbe; ls_addr = la; ls_wdata = lwd;
        if (r) begin
            denied = 0;
            own    = 0;
        end
        #1;
        egi = ir && (!lr || denied == MS);
        egl = lr && !egi;
        ewe = (egl && lwe) ? lbe : 4'b0000;
        chk("if_gnt", 32'(if_gnt), 32'(egi));
        chk("ls_gnt", 32'(ls_gnt), 32'(egl));
        chk("mem_en", 32'(mem_en), 32'(egi | egl));
        chk("mem_we", 32'(mem_we), 32'(ewe));
        if (egi) chk("mem_addr_if", 32'(mem_addr), 32'(ia));
        if (egl) chk("mem_addr_ls", 32'(mem_addr), 32'(la));
        if (egl && lwe) chk("mem_wdata", mem_wdata, lwd);
        chk("if_rvalid", 32'(if_rvalid), 32'(own == 1));
        chk("ls_rvalid", 32'(ls_rvalid), 32'(own == 2));
        if (own == 1) chk("if_rdata", if_rdata, own_data);
        if (own == 2 && !own_store) chk("ls_rdata", ls_rdata, own_data);
        obs_if = if_gnt;
        gi = egi;
        gl = egl;
        nd   = (!ir || egi) ? 0 : denied + 1;
        nown = egi ? 1 : (egl ? 2 : 0);
        nst  = egl && lwe;
        sel  = egi ? ia : la;
        ndat = tie ? 32'(sel) : ref_mem[sel[9:0]];
        @(posedge clk);
        if (r) begin
            denied = 0;
            own    = 0;
            for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        end else begin
            denied    = nd;
            own       = nown;
            own_store = nst;
            own_data  = ndat;
            if (nst)
                for (int b = 0; b < 4; b++)
                    if (lbe[b]) ref_mem[la[9:0]][8*b +: 8] = lwd[8*b +: 8];
        end
    endtask

    logic          gi, gl, oi;
    logic          if_pend, ls_pend, lp_we;
    logic [AW-1:0] ip_a, lp_a;
    logic [3:0]    lp_be;
    logic [31:0]   lp_wd;

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
        ls_be = 4'h0; ls_addr = '0; ls_wdata = 32'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);

        // Reset state: no grants, no responses, memory port idle.
        cyc(1, 0, '0, 0, 0, 4'h0, '0, 32'h0, gi, gl, oi);
        cyc(1, 0, '0, 0, 0, 4'h0, '0, 32'h0, gi, gl, oi);
        cyc(0, 0, '0, 0, 0, 4'h0, '0, 32'h0, gi, gl, oi);

        // Fetch only from 0x010 (data 0x13), three back-to-back grants.
        for (int i = 0; i < 3; i++) cyc(0, 1, 14'h010, 0, 0, 4'h0, '0, 32'h0, gi, gl, oi);
        cyc(0, 0, '0, 0, 0, 4'h0, '0, 32'h0, gi, gl, oi);
        chk("fetch_data_0x13", if_rdata, 32'h0000_0013);

        // Store half-word to 0x020, then load it back.
        cyc(0, 0, '0, 1, 1, 4'b0011, 14'h020, 32'hDEAD_BEEF, gi, gl, oi);
        cyc(0, 0, '0, 1, 0, 4'b0000, 14'h020, 32'h0, gi, gl, oi);
        cyc(0, 0, '0, 0, 0, 4'h0, '0, 32'h0, gi, gl, oi);
        chk("load_after_store_low", 32'(ls_rdata[15:0]), 32'h0000_BEEF);

        // Contention: LS,LS,LS,LS,IF repeating.
        for (int i = 0; i < 15; i++) begin
            cyc(0, 1, 14'h030, 1, 0, 4'h0, 14'h031, 32'h0, gi, gl, oi);
            chk("contention_if_gnt", 32'(oi), 32'(i % 5 == 4));
        end
        cyc(0, 0, '0, 0, 0, 4'h0, '0, 32'h0, gi, gl, oi);

        // Fetch drops while stalled: counter restarts, IF waits 4 more LS grants.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 14'h040, 1, 0, 4'h0, 14'h041, 32'h0, gi, gl, oi);
            chk("drop_pre_if_gnt", 32'(oi), 32'h0);
        end
        cyc(0, 0, '0, 1, 0, 4'h0, 14'h041, 32'h0, gi, gl, oi);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 14'h040, 1, 0, 4'h0, 14'h041, 32'h0, gi, gl, oi);
            chk("drop_post_if_gnt", 32'(oi), 32'(i == 4));
        end
        cyc(0, 0, '0, 0, 0, 4'h0, '0, 32'h0, gi, gl, oi);

        // Build up a stall, then reset the cycle after an LS grant.
        cyc(0, 1, 14'h050, 1, 0, 4'h0, 14'h051, 32'h0, gi, gl, oi);
        cyc(0, 1, 14'h050, 1, 0, 4'h0, 14'h051, 32'h0, gi, gl, oi);
        cyc(1, 0, '0, 0, 0, 4'h0, '0, 32'h0, gi, gl, oi);
        chk("reset_drop_ls_rvalid", 32'(ls_rvalid), 32'h0);
        cyc(1, 0, '0, 0, 0, 4'h0, '0, 32'h0, gi, gl, oi);
        cyc(0, 0, '0, 0, 0, 4'h0, '0, 32'h0, gi, gl, oi);
        // Post-reset stall counter starts from zero: IF forced on the 5th.
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 14'h060, 1, 0, 4'h0, 14'h061, 32'h0, gi, gl, oi);
            chk("post_reset_if_gnt", 32'(oi), 32'(i == 4));
        end
        cyc(0, 0, '0, 0, 0, 4'h0, '0, 32'h0, gi, gl, oi);

        // Interleaved IF/LS with data tied to address: no response swaps.
        tie = 1'b1;
        for (int i = 0; i < 8; i++)
            cyc(0, i % 2 == 0, 14'h100, i % 2 == 1, 0, 4'h0, 14'h200, 32'h0, gi, gl, oi);
        cyc(0, 0, '0, 0, 0, 4'h0, '0, 32'h0, gi, gl, oi);
        tie = 1'b0;

        // Random traffic with held requests, checked against the model.
        if_pend = 1'b0; ls_pend = 1'b0;
        ip_a = '0; lp_a = '0; lp_we = 1'b0; lp_be = 4'h0; lp_wd = 32'h0;
        for (int n = 0; n < 500; n++) begin
            if (!if_pend && $urandom_range(0, 2) != 0) begin
                if_pend = 1'b1;
                ip_a    = AW'($urandom_range(0, 1023));
            end
            if (!ls_pend && $urandom_range(0, 2) != 0) begin
                ls_pend = 1'b1;
                lp_we   = 1'($urandom_range(0, 1));
                lp_be   = 4'($urandom);
                lp_a    = AW'($urandom_range(0, 63));
                lp_wd   = $urandom;
            end
            cyc(0, if_pend, if_pend ? ip_a : '0, ls_pend, lp_we, lp_be,
                ls_pend ? lp_a : '0, lp_wd, gi, gl, oi);
            if (gi) if_pend = 1'b0;
            if (gl) ls_pend = 1'b0;
        end
        cyc(0, 0, '0, 0, 0, 4'h0, '0, 32'h0, gi, gl, oi);
        cyc(0, 0, '0, 0, 0, 4'h0, '0, 32'h0, gi, gl, oi);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
